// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : core_pkg
//  Description : Shared constants for the 5-stage RV32 core. The datapath and
//                the pipeline-register bank both take the payload widths from
//                here, so the two sides always agree on bus widths.
//                Also holds the per-edge register action encoding
//                (flush > stall > load) used by every stage register.
//  Revision    : 1.0  initial release
// ============================================================================
package core_pkg;

  localparam int XLEN  = 32;
  localparam int W_EX  = 160;
  localparam int W_ME  = 96;
  localparam int W_WB  = 72;
  localparam int CNT_W = 32;

  localparam logic [XLEN-1:0] PC_RESET = 32'h0000_0000;

  // What a stage register does at a clock edge.
  typedef enum logic [1:0] {
    REG_LOAD  = 2'd0,
    REG_STALL = 2'd1,
    REG_FLUSH = 2'd2
  } reg_action_e;

  // Flush overrides stall; a register with neither control loads.
  function automatic reg_action_e reg_action(input logic stall, input logic flush);
    if (flush) begin
      return REG_FLUSH;
    end
    if (stall) begin
      return REG_STALL;
    end
    return REG_LOAD;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipeline_stage_regs_if.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_stage_regs_if
//  Description : Signal bundle between the datapath/hazard unit and the
//                pipeline-register bank.
//                master : hazard controls, next PC, fetched instruction and
//                         stage payloads in; register contents, valids and
//                         perf counters out.
//                slave  : the register bank (mirror of master).
//  Revision    : 1.0  initial release
// ============================================================================
interface pipeline_stage_regs_if;
  import core_pkg::*;

  // hazard-unit controls (IF->PC, ID->IF/ID, EX->ID/EX, ME->EX/ME, WB->ME/WB)
  logic stall_IF, stall_ID, stall_EX, stall_ME, stall_WB;
  logic flush_IF, flush_ID, flush_EX, flush_ME, flush_WB;

  // datapath inputs
  logic [XLEN-1:0] pc_next;
  logic [XLEN-1:0] inst_IF;
  logic [W_EX-1:0] d_ID;
  logic [W_ME-1:0] d_EX;
  logic [W_WB-1:0] d_ME;

  // register contents
  logic [XLEN-1:0] pc_IF;
  logic [XLEN-1:0] pc_ID;
  logic [XLEN-1:0] inst_ID;
  logic [W_EX-1:0] q_EX;
  logic [W_ME-1:0] q_ME;
  logic [W_WB-1:0] q_WB;
  logic            valid_ID, valid_EX, valid_ME, valid_WB;

  // perf counters
  logic [CNT_W-1:0] cycle_cnt, instret_cnt, stall_cnt, flush_cnt;

  modport master (
    output stall_IF, stall_ID, stall_EX, stall_ME, stall_WB,
    output flush_IF, flush_ID, flush_EX, flush_ME, flush_WB,
    output pc_next, inst_IF, d_ID, d_EX, d_ME,
    input  pc_IF, pc_ID, inst_ID, q_EX, q_ME, q_WB,
    input  valid_ID, valid_EX, valid_ME, valid_WB,
    input  cycle_cnt, instret_cnt, stall_cnt, flush_cnt
  );

  modport slave (
    input  stall_IF, stall_ID, stall_EX, stall_ME, stall_WB,
    input  flush_IF, flush_ID, flush_EX, flush_ME, flush_WB,
    input  pc_next, inst_IF, d_ID, d_EX, d_ME,
    output pc_IF, pc_ID, inst_ID, q_EX, q_ME, q_WB,
    output valid_ID, valid_EX, valid_ME, valid_WB,
    output cycle_cnt, instret_cnt, stall_cnt, flush_cnt
  );

endinterface
`default_nettype wire

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_stage_reg
//  Description : One pipeline register: W bits of data plus a valid bit.
//                Per edge: flush (data <- RESET_VAL, valid <- 0), else stall
//                (hold), else load (data <- d, valid <- valid_in).
//                Asynchronous active-high reset to RESET_VAL / invalid.
//  Ports       : clk, rst          clock, async reset
//                stall, flush      hazard controls for this register
//                d, valid_in       upstream contents
//                q, valid          registered contents
//  Revision    : 1.0  initial release
// ============================================================================
module pipe_stage_reg
  import core_pkg::*;
#(
  parameter int           W         = 32,
  parameter logic [W-1:0] RESET_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         stall,
  input  logic         flush,
  input  logic [W-1:0] d,
  input  logic         valid_in,
  output logic [W-1:0] q,
  output logic         valid
);

  logic [W-1:0] data_d, data_q;
  logic         valid_d, valid_q;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    case (reg_action(stall, flush))
      REG_FLUSH: begin
        data_d  = RESET_VAL;
        valid_d = 1'b0;
      end
      REG_STALL: begin
        data_d  = data_q;
        valid_d = valid_q;
      end
      default: begin
        data_d  = d;
        valid_d = valid_in;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= RESET_VAL;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign q     = data_q;
  assign valid = valid_q;

endmodule
`default_nettype wire

// File: rtl/pipeline_stage_regs.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_stage_regs
//  Description : Pipeline-register bank of the 5-stage RV32 core: PC, IF/ID,
//                ID/EX, EX/ME and ME/WB registers with a valid bit per stage,
//                driven by the hazard unit's stall/flush pairs. Also keeps the
//                cycle / retire / stall / flush perf counters (wrap mod 2^32).
//                All outputs come straight from flops.
//  Ports       : clk, rst   clock, asynchronous active-high reset
//                bus        pipeline_stage_regs_if.slave (controls, payloads,
//                           register contents, valids, counters)
//  Revision    : 1.0  initial release
// ============================================================================
module pipeline_stage_regs
  import core_pkg::*;
#(
  parameter logic [XLEN-1:0] PC_RESET_VAL = PC_RESET
) (
  input  logic                  clk,
  input  logic                  rst,
  pipeline_stage_regs_if.slave  bus
);

  logic [XLEN-1:0]   pc_if;
  logic [2*XLEN-1:0] ifid_q;
  logic [W_EX-1:0]   idex_q;
  logic [W_ME-1:0]   exme_q;
  logic [W_WB-1:0]   mewb_q;
  logic              valid_id, valid_ex, valid_me, valid_wb;
  logic              pc_valid_unused;

  // --------------------------------------------------------------------------
  // Stage registers. Each one loads from upstream whenever it is itself
  // neither stalled nor flushed; the hazard unit is responsible for flushing
  // the downstream copy of a stalled instruction.
  // --------------------------------------------------------------------------
  pipe_stage_reg #(
    .W         (XLEN),
    .RESET_VAL (PC_RESET_VAL)
  ) u_pc (
    .clk      (clk),
    .rst      (rst),
    .stall    (bus.stall_IF),
    .flush    (bus.flush_IF),
    .d        (bus.pc_next),
    .valid_in (1'b1),
    .q        (pc_if),
    .valid    (pc_valid_unused)
  );

  // Anything leaving the PC register is a real fetch, so IF/ID valid is 1.
  pipe_stage_reg #(
    .W         (2*XLEN),
    .RESET_VAL ('0)
  ) u_ifid (
    .clk      (clk),
    .rst      (rst),
    .stall    (bus.stall_ID),
    .flush    (bus.flush_ID),
    .d        ({pc_if, bus.inst_IF}),
    .valid_in (1'b1),
    .q        (ifid_q),
    .valid    (valid_id)
  );

  pipe_stage_reg #(
    .W         (W_EX),
    .RESET_VAL ('0)
  ) u_idex (
    .clk      (clk),
    .rst      (rst),
    .stall    (bus.stall_EX),
    .flush    (bus.flush_EX),
    .d        (bus.d_ID),
    .valid_in (valid_id),
    .q        (idex_q),
    .valid    (valid_ex)
  );

  pipe_stage_reg #(
    .W         (W_ME),
    .RESET_VAL ('0)
  ) u_exme (
    .clk      (clk),
    .rst      (rst),
    .stall    (bus.stall_ME),
    .flush    (bus.flush_ME),
    .d        (bus.d_EX),
    .valid_in (valid_ex),
    .q        (exme_q),
    .valid    (valid_me)
  );

  pipe_stage_reg #(
    .W         (W_WB),
    .RESET_VAL ('0)
  ) u_mewb (
    .clk      (clk),
    .rst      (rst),
    .stall    (bus.stall_WB),
    .flush    (bus.flush_WB),
    .d        (bus.d_ME),
    .valid_in (valid_me),
    .q        (mewb_q),
    .valid    (valid_wb)
  );

  // --------------------------------------------------------------------------
  // Perf counters. An instruction retires when it sits valid in ME/WB and
  // is not held there by a WB stall.
  // --------------------------------------------------------------------------
  logic [CNT_W-1:0] cycle_cnt_d,   cycle_cnt_q;
  logic [CNT_W-1:0] instret_cnt_d, instret_cnt_q;
  logic [CNT_W-1:0] stall_cnt_d,   stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_d,   flush_cnt_q;

  always_comb begin
    cycle_cnt_d   = cycle_cnt_q   + CNT_W'(1);
    instret_cnt_d = instret_cnt_q + CNT_W'(valid_wb & ~bus.stall_WB);
    stall_cnt_d   = stall_cnt_q   + CNT_W'(bus.stall_IF);
    flush_cnt_d   = flush_cnt_q   + CNT_W'(bus.flush_ID);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_cnt_q   <= '0;
      instret_cnt_q <= '0;
      stall_cnt_q   <= '0;
      flush_cnt_q   <= '0;
    end else begin
      cycle_cnt_q   <= cycle_cnt_d;
      instret_cnt_q <= instret_cnt_d;
      stall_cnt_q   <= stall_cnt_d;
      flush_cnt_q   <= flush_cnt_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.pc_IF       = pc_if;
  assign bus.pc_ID       = ifid_q[2*XLEN-1:XLEN];
  assign bus.inst_ID     = ifid_q[XLEN-1:0];
  assign bus.q_EX        = idex_q;
  assign bus.q_ME        = exme_q;
  assign bus.q_WB        = mewb_q;
  assign bus.valid_ID    = valid_id;
  assign bus.valid_EX    = valid_ex;
  assign bus.valid_ME    = valid_me;
  assign bus.valid_WB    = valid_wb;
  assign bus.cycle_cnt   = cycle_cnt_q;
  assign bus.instret_cnt = instret_cnt_q;
  assign bus.stall_cnt   = stall_cnt_q;
  assign bus.flush_cnt   = flush_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_stage_regs.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_pipeline_stage_regs
//  Description : Self-checking bench for pipeline_stage_regs: a hand-derived
//                vector table for the directed pipeline scenarios, an async
//                mid-run reset, a randomized run against a behavioural model
//                and a cycle-counter wrap.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pipeline_stage_regs;
  import core_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipeline_stage_regs_if bus ();

  pipeline_stage_regs dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [191:0] rnd192();
    logic [191:0] r;
    for (int i = 0; i < 6; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  // ---------------- behavioural reference model ----------------
  // Stage index: 0 = IF/ID, 1 = ID/EX, 2 = EX/ME, 3 = ME/WB.
  logic [XLEN-1:0]  m_pc, m_pc_id, m_inst_id;
  logic [W_EX-1:0]  m_qex;
  logic [W_ME-1:0]  m_qme;
  logic [W_WB-1:0]  m_qwb;
  logic             m_v [4];
  logic [CNT_W-1:0] m_cyc, m_ret, m_stl, m_fl;

  task automatic model_reset();
    m_pc = PC_RESET; m_pc_id = '0; m_inst_id = '0;
    m_qex = '0; m_qme = '0; m_qwb = '0;
    for (int i = 0; i < 4; i++) m_v[i] = 1'b0;
    m_cyc = '0; m_ret = '0; m_stl = '0; m_fl = '0;
  endtask

  // st/fl bit 0 = IF (PC), 1 = ID, 2 = EX, 3 = ME, 4 = WB.
  task automatic model_step(input logic [4:0] st, input logic [4:0] fl,
                            input logic [XLEN-1:0] pcn, input logic [XLEN-1:0] inst,
                            input logic [W_EX-1:0] did, input logic [W_ME-1:0] dex,
                            input logic [W_WB-1:0] dme);
    logic             ov [4];
    logic [XLEN-1:0]  opc;
    for (int i = 0; i < 4; i++) ov[i] = m_v[i];
    opc = m_pc;
    m_cyc = m_cyc + 1;
    if (ov[3] && !st[4]) m_ret = m_ret + 1;
    if (st[0]) m_stl = m_stl + 1;
    if (fl[1]) m_fl = m_fl + 1;
    if (fl[0]) m_pc = PC_RESET; else if (!st[0]) m_pc = pcn;
    if (fl[1]) begin m_v[0] = 0; m_pc_id = '0; m_inst_id = '0; end
    else if (!st[1]) begin m_v[0] = 1; m_pc_id = opc; m_inst_id = inst; end
    if (fl[2]) begin m_v[1] = 0; m_qex = '0; end
    else if (!st[2]) begin m_v[1] = ov[0]; m_qex = did; end
    if (fl[3]) begin m_v[2] = 0; m_qme = '0; end
    else if (!st[3]) begin m_v[2] = ov[1]; m_qme = dex; end
    if (fl[4]) begin m_v[3] = 0; m_qwb = '0; end
    else if (!st[4]) begin m_v[3] = ov[2]; m_qwb = dme; end
  endtask

  task automatic check_model();
    check("pc_IF",       160'(bus.pc_IF),       160'(m_pc));
    check("pc_ID",       160'(bus.pc_ID),       160'(m_pc_id));
    check("inst_ID",     160'(bus.inst_ID),     160'(m_inst_id));
    check("q_EX",        160'(bus.q_EX),        160'(m_qex));
    check("q_ME",        160'(bus.q_ME),        160'(m_qme));
    check("q_WB",        160'(bus.q_WB),        160'(m_qwb));
    check("valids",      160'({bus.valid_ID, bus.valid_EX, bus.valid_ME, bus.valid_WB}),
                         160'({m_v[0], m_v[1], m_v[2], m_v[3]}));
    check("cycle_cnt",   160'(bus.cycle_cnt),   160'(m_cyc));
    check("instret_cnt", 160'(bus.instret_cnt), 160'(m_ret));
    check("stall_cnt",   160'(bus.stall_cnt),   160'(m_stl));
    check("flush_cnt",   160'(bus.flush_cnt),   160'(m_fl));
  endtask

  // ---------------- stimulus ----------------
  logic [XLEN-1:0] cur_inst;
  logic [W_EX-1:0] cur_did;
  logic [W_ME-1:0] cur_dex;
  logic [W_WB-1:0] cur_dme;

  task automatic drive(input logic [4:0] st, input logic [4:0] fl, input logic [XLEN-1:0] pcn);
    {bus.stall_WB, bus.stall_ME, bus.stall_EX, bus.stall_ID, bus.stall_IF} = st;
    {bus.flush_WB, bus.flush_ME, bus.flush_EX, bus.flush_ID, bus.flush_IF} = fl;
    cur_inst = bus.pc_IF ^ 32'hA5A5_0000;
    cur_did  = W_EX'(rnd192());
    cur_dex  = W_ME'(rnd192());
    cur_dme  = W_WB'(rnd192());
    bus.pc_next = pcn;
    bus.inst_IF = cur_inst;
    bus.d_ID    = cur_did;
    bus.d_EX    = cur_dex;
    bus.d_ME    = cur_dme;
  endtask

  typedef struct {
    logic [4:0]  st;
    logic [4:0]  fl;
    logic        use_tgt;
    logic [31:0] tgt;
    logic [31:0] e_pc_if;
    logic [31:0] e_pc_id;
    logic [3:0]  e_valid;   // {ID, EX, ME, WB}
    logic [31:0] e_cyc;
    logic [31:0] e_ret;
    logic [31:0] e_stl;
    logic [31:0] e_fl;
    logic        e_qex_zero;
  } vec_t;

  function automatic vec_t mk(input logic [4:0] st, input logic [4:0] fl, input logic ut,
                              input logic [31:0] tgt, input logic [31:0] pif, input logic [31:0] pid,
                              input logic [3:0] v, input logic [31:0] cyc, input logic [31:0] ret,
                              input logic [31:0] stl, input logic [31:0] flc, input logic qz);
    vec_t r;
    r.st = st; r.fl = fl; r.use_tgt = ut; r.tgt = tgt; r.e_pc_if = pif; r.e_pc_id = pid;
    r.e_valid = v; r.e_cyc = cyc; r.e_ret = ret; r.e_stl = stl; r.e_fl = flc; r.e_qex_zero = qz;
    return r;
  endfunction

  vec_t tbl [14];

  initial begin
    logic [4:0] rs, rf;
    logic [XLEN-1:0] pcn;

    // Free-run, load-use, branch, flush+stall on ID/EX, then refill.
    tbl[0]  = mk(5'b00000, 5'b00000, 0, 0, 32'h004, 32'h000, 4'b1000,  1, 0, 0, 0, 0);
    tbl[1]  = mk(5'b00000, 5'b00000, 0, 0, 32'h008, 32'h004, 4'b1100,  2, 0, 0, 0, 0);
    tbl[2]  = mk(5'b00000, 5'b00000, 0, 0, 32'h00C, 32'h008, 4'b1110,  3, 0, 0, 0, 0);
    tbl[3]  = mk(5'b00000, 5'b00000, 0, 0, 32'h010, 32'h00C, 4'b1111,  4, 0, 0, 0, 0);
    tbl[4]  = mk(5'b00000, 5'b00000, 0, 0, 32'h014, 32'h010, 4'b1111,  5, 1, 0, 0, 0);
    tbl[5]  = mk(5'b00011, 5'b00100, 0, 0, 32'h014, 32'h010, 4'b1011,  6, 2, 1, 0, 1);
    tbl[6]  = mk(5'b00000, 5'b00000, 0, 0, 32'h018, 32'h014, 4'b1101,  7, 3, 1, 0, 0);
    tbl[7]  = mk(5'b00000, 5'b00000, 0, 0, 32'h01C, 32'h018, 4'b1110,  8, 4, 1, 0, 0);
    tbl[8]  = mk(5'b00000, 5'b00000, 0, 0, 32'h020, 32'h01C, 4'b1111,  9, 4, 1, 0, 0);
    tbl[9]  = mk(5'b00000, 5'b00110, 1, 32'h100, 32'h100, 32'h000, 4'b0011, 10, 5, 1, 1, 1);
    tbl[10] = mk(5'b00100, 5'b00100, 0, 0, 32'h104, 32'h100, 4'b1001, 11, 6, 1, 1, 1);
    tbl[11] = mk(5'b00000, 5'b00000, 0, 0, 32'h108, 32'h104, 4'b1100, 12, 7, 1, 1, 0);
    tbl[12] = mk(5'b00000, 5'b00000, 0, 0, 32'h10C, 32'h108, 4'b1110, 13, 7, 1, 1, 0);
    tbl[13] = mk(5'b00000, 5'b00000, 0, 0, 32'h110, 32'h10C, 4'b1111, 14, 7, 1, 1, 0);

    drive(5'b0, 5'b0, 32'h0);

    // ---- reset state ----
    repeat (2) @(posedge clk);
    #1;
    check("rst_pc_IF",  160'(bus.pc_IF), 160'(PC_RESET));
    check("rst_valids", 160'({bus.valid_ID, bus.valid_EX, bus.valid_ME, bus.valid_WB}), 160'(0));
    check("rst_q_EX",   160'(bus.q_EX), 160'(0));
    check("rst_cycle",  160'(bus.cycle_cnt), 160'(0));
    rst = 1'b0;

    // ---- directed table ----
    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].st, tbl[i].fl, tbl[i].use_tgt ? tbl[i].tgt : bus.pc_IF + 32'd4);
      @(posedge clk);
      #1;
      check($sformatf("t%0d_pc_IF", i), 160'(bus.pc_IF), 160'(tbl[i].e_pc_if));
      check($sformatf("t%0d_pc_ID", i), 160'(bus.pc_ID), 160'(tbl[i].e_pc_id));
      check($sformatf("t%0d_valid", i),
            160'({bus.valid_ID, bus.valid_EX, bus.valid_ME, bus.valid_WB}), 160'(tbl[i].e_valid));
      check($sformatf("t%0d_cycle", i),   160'(bus.cycle_cnt),   160'(tbl[i].e_cyc));
      check($sformatf("t%0d_instret", i), 160'(bus.instret_cnt), 160'(tbl[i].e_ret));
      check($sformatf("t%0d_stall", i),   160'(bus.stall_cnt),   160'(tbl[i].e_stl));
      check($sformatf("t%0d_flush", i),   160'(bus.flush_cnt),   160'(tbl[i].e_fl));
      if (tbl[i].e_qex_zero) check($sformatf("t%0d_q_EX_zero", i), 160'(bus.q_EX), 160'(0));
    end

    // ---- async reset between edges with every stage valid ----
    drive(5'b0, 5'b0, bus.pc_IF + 32'd4);
    #2;
    rst = 1'b1;
    #1;
    check("arst_valids", 160'({bus.valid_ID, bus.valid_EX, bus.valid_ME, bus.valid_WB}), 160'(0));
    check("arst_pc_IF",  160'(bus.pc_IF), 160'(PC_RESET));
    check("arst_q_WB",   160'(bus.q_WB), 160'(0));
    check("arst_cnts",   160'({bus.cycle_cnt, bus.instret_cnt, bus.stall_cnt, bus.flush_cnt}), 160'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();

    // ---- randomized run against the model ----
    for (int n = 0; n < 400; n++) begin
      for (int b = 0; b < 5; b++) begin
        rs[b] = ($urandom_range(5) == 0);
        rf[b] = ($urandom_range(7) == 0);
      end
      pcn = ($urandom_range(7) == 0) ? {$urandom_range(32'hFFFF), 2'b00} : bus.pc_IF + 32'd4;
      drive(rs, rf, pcn);
      model_step(rs, rf, pcn, cur_inst, cur_did, cur_dex, cur_dme);
      @(posedge clk);
      #1;
      check_model();
    end

    // ---- cycle counter wrap ----
    force dut.cycle_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.cycle_cnt_q;
    #1;
    check("wrap_preload", 160'(bus.cycle_cnt), 160'(32'hFFFF_FFFF));
    m_cyc = 32'hFFFF_FFFF;
    drive(5'b0, 5'b0, bus.pc_IF + 32'd4);
    model_step(5'b0, 5'b0, bus.pc_IF + 32'd4, cur_inst, cur_did, cur_dex, cur_dme);
    @(posedge clk);
    #1;
    check("wrap_cycle", 160'(bus.cycle_cnt), 160'(0));
    check_model();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
